csr_unit: RTL and testbench

//  Machine-mode CSR register file and access responder for the RV64 core.
//  - Serves CSR instructions flagged is_csr by the decoder; funct3 carries the op.
//  - Keeps trap state (mepc/mcause/mtval/mstatus) and the mcycle/minstret counters.
//  - Sits beside execute; one request accepted per cycle, response registered.

---
 rtl/riscv_pkg.sv | 53 +++++
 rtl/csr_unit_counter.sv | 21 ++
 rtl/csr_unit.sv | 181 ++++++++++++++++++
 tb/tb_csr_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the machine-mode CSR unit:
// CSR op codes, CSR addresses, mstatus fields, misa and cause codes.
package riscv;

  localparam int XLEN = 64;

  typedef logic [11:0] csr_reg_t;

  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_t;

  localparam csr_reg_t CSR_MSTATUS   = 12'h300;
  localparam csr_reg_t CSR_MISA      = 12'h301;
  localparam csr_reg_t CSR_MIE       = 12'h304;
  localparam csr_reg_t CSR_MTVEC     = 12'h305;
  localparam csr_reg_t CSR_MSCRATCH  = 12'h340;
  localparam csr_reg_t CSR_MEPC      = 12'h341;
  localparam csr_reg_t CSR_MCAUSE    = 12'h342;
  localparam csr_reg_t CSR_MTVAL     = 12'h343;
  localparam csr_reg_t CSR_MIP       = 12'h344;
  localparam csr_reg_t CSR_MCYCLE    = 12'hB00;
  localparam csr_reg_t CSR_MINSTRET  = 12'hB02;
  localparam csr_reg_t CSR_CYCLE     = 12'hC00;
  localparam csr_reg_t CSR_INSTRET   = 12'hC02;
  localparam csr_reg_t CSR_MVENDORID = 12'hF11;
  localparam csr_reg_t CSR_MARCHID   = 12'hF12;
  localparam csr_reg_t CSR_MIMPID    = 12'hF13;
  localparam csr_reg_t CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // MXL=2 (RV64), extensions I and M
  localparam logic [63:0] MISA_VAL = 64'h8000_0000_0000_1100;

  localparam logic [63:0] CAUSE_INSN_MISALIGNED = 64'd0;
  localparam logic [63:0] CAUSE_ILLEGAL_INSN    = 64'd2;
  localparam logic [63:0] CAUSE_BREAKPOINT      = 64'd3;
  localparam logic [63:0] CAUSE_ECALL_M         = 64'd11;

  function automatic logic csr_is_ro(csr_reg_t a);
    return a[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_unit_counter.sv
// 64-bit free-running counter with increment enable and
// a write override that wins over the increment.
module csr_counter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] value
);

  // count up, wrap silently, software write takes precedence
  always_ff @(posedge clk) begin
    if (rst)      value <= '0;
    else if (we)  value <= wdata;
    else if (inc) value <= value + 1'b1;
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: serves CSR instructions, holds trap
// state and the mcycle/minstret counters.
module csr_unit
  import riscv::*;
#(
  parameter int              XLEN      = riscv::XLEN,
  parameter logic [XLEN-1:0] HART_ID   = '0,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            req_rs1_zero,
  input  logic            req_rd_v,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_illegal,
  input  logic            retire_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_epc_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o
);

  localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);

  logic            st_mie;
  logic            st_mpie;
  logic [XLEN-1:0] mie_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;
  logic [XLEN-1:0] mcycle;
  logic [XLEN-1:0] minstret;
  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic [XLEN-1:0] rd_val;
  logic            addr_ok;
  logic            op_ok;
  logic            wr_req;
  logic            illegal;
  logic            accept;
  logic            do_write;

  assign req_ready = ~trap_i & ~mret_i;
  assign accept    = req_valid & req_ready;
  assign op_ok     = req_op[1:0] != 2'b00;
  assign wr_req    = (req_op[1:0] == 2'b01) | ~req_rs1_zero;
  assign illegal   = ~addr_ok | ~op_ok | (wr_req & csr_is_ro(req_addr));
  assign do_write  = accept & ~illegal & wr_req;
  assign mtvec_o   = mtvec_q;
  assign mepc_o    = mepc_q;

  // mstatus view: MPP hardwired to machine mode
  always_comb begin
    mstatus_val = '0;
    mstatus_val[MSTATUS_MIE]  = st_mie;
    mstatus_val[MSTATUS_MPIE] = st_mpie;
    mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  // CSR read decode; unknown addresses flag illegal
  always_comb begin
    addr_ok = 1'b1;
    old_val = '0;
    case (req_addr)
      CSR_MSTATUS:  old_val = mstatus_val;
      CSR_MISA:     old_val = XLEN'(MISA_VAL);
      CSR_MIE:      old_val = mie_q;
      CSR_MTVEC:    old_val = mtvec_q;
      CSR_MSCRATCH: old_val = mscratch_q;
      CSR_MEPC:     old_val = mepc_q;
      CSR_MCAUSE:   old_val = mcause_q;
      CSR_MTVAL:    old_val = mtval_q;
      CSR_MIP:      old_val = '0;
      CSR_MCYCLE,
      CSR_CYCLE:    old_val = mcycle;
      CSR_MINSTRET,
      CSR_INSTRET:  old_val = minstret;
      CSR_MVENDORID,
      CSR_MARCHID,
      CSR_MIMPID:   old_val = '0;
      CSR_MHARTID:  old_val = HART_ID;
      default:      addr_ok = 1'b0;
    endcase
  end

  // write value from op kind; rd=x0 on RW skips the read
  always_comb begin
    new_val = req_wdata;
    rd_val  = old_val;
    unique case (1'b1)
      req_op[1:0] == 2'b10: new_val = old_val | req_wdata;
      req_op[1:0] == 2'b11: new_val = old_val & ~req_wdata;
      default:              new_val = req_wdata;
    endcase
    if (req_op[1:0] == 2'b01 && !req_rd_v) rd_val = '0;
  end

  // architectural state: trap beats mret beats software write
  always_ff @(posedge clk) begin
    if (rst) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST & ALIGN;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      if (do_write) begin
        case (req_addr)
          CSR_MSTATUS: begin
            st_mie  <= new_val[MSTATUS_MIE];
            st_mpie <= new_val[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_q      <= new_val;
          CSR_MTVEC:    mtvec_q    <= new_val & ALIGN;
          CSR_MSCRATCH: mscratch_q <= new_val;
          CSR_MEPC:     mepc_q     <= new_val & ALIGN;
          CSR_MCAUSE:   mcause_q   <= new_val;
          CSR_MTVAL:    mtval_q    <= new_val;
          default:      ;
        endcase
      end
      if (trap_i) begin
        mepc_q   <= trap_epc_i & ALIGN;
        mcause_q <= trap_cause_i;
        mtval_q  <= trap_tval_i;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
      end else if (mret_i) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end
    end
  end

  // registered response, one cycle after acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_illegal <= 1'b0;
    end else begin
      rsp_valid   <= accept;
      rsp_illegal <= accept & illegal;
      rsp_rdata   <= (accept & ~illegal) ? rd_val : '0;
    end
  end

  csr_counter #(.XLEN(XLEN)) u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .we    (do_write & (req_addr == CSR_MCYCLE)),
    .wdata (new_val),
    .value (mcycle)
  );

  csr_counter #(.XLEN(XLEN)) u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire_i),
    .we    (do_write & (req_addr == CSR_MINSTRET)),
    .wdata (new_val),
    .value (minstret)
  );

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: directed scenarios plus random traffic
// checked cycle by cycle against a behavioural CSR model.
module tb_csr_unit;

  localparam logic [63:0] MTVEC_RST = 64'h1003;
  localparam logic [2:0] OP_RW = 3'b001;
  localparam logic [2:0] OP_RS = 3'b010;
  localparam logic [2:0] OP_RC = 3'b011;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_rs1_zero;
  logic        req_rd_v;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_illegal;
  logic        retire_i;
  logic        trap_i;
  logic [63:0] trap_cause_i;
  logic [63:0] trap_epc_i;
  logic [63:0] trap_tval_i;
  logic        mret_i;
  logic [63:0] mtvec_o;
  logic [63:0] mepc_o;

  always #5 clk = ~clk;

  csr_unit #(
    .XLEN      (64),
    .HART_ID   (64'h0),
    .MTVEC_RST (MTVEC_RST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rs1_zero (req_rs1_zero),
    .req_rd_v     (req_rd_v),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_illegal  (rsp_illegal),
    .retire_i     (retire_i),
    .trap_i       (trap_i),
    .trap_cause_i (trap_cause_i),
    .trap_epc_i   (trap_epc_i),
    .trap_tval_i  (trap_tval_i),
    .mret_i       (mret_i),
    .mtvec_o      (mtvec_o),
    .mepc_o       (mepc_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // behavioural model state
  logic        m_mie, m_mpie;
  logic [63:0] m_ie, m_tvec, m_scratch, m_epc, m_cause, m_tval;
  logic [63:0] m_cycle, m_instret;
  logic        e_valid, e_ill;
  logic [63:0] e_rdata;

  logic [11:0] addrs [20] = '{
    12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
    12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hC00,
    12'hC02, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7FF,
    12'h123, 12'hC01
  };

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_read(input logic [11:0] a,
                            output bit ok, output logic [63:0] v);
    ok = 1'b1;
    v  = 64'h0;
    case (a)
      12'h300: v = 64'h1800 | (64'(m_mpie) << 7) | (64'(m_mie) << 3);
      12'h301: v = 64'h8000_0000_0000_1100;
      12'h304: v = m_ie;
      12'h305: v = m_tvec;
      12'h340: v = m_scratch;
      12'h341: v = m_epc;
      12'h342: v = m_cause;
      12'h343: v = m_tval;
      12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14: v = 64'h0;
      12'hB00, 12'hC00: v = m_cycle;
      12'hB02, 12'hC02: v = m_instret;
      default: ok = 1'b0;
    endcase
  endtask

  task automatic model_step();
    bit ok, wr, cyc_w, ins_w;
    logic [63:0] old, nv;
    logic [1:0] kind;
    e_valid = 1'b0;
    e_ill   = 1'b0;
    e_rdata = 64'h0;
    cyc_w   = 1'b0;
    ins_w   = 1'b0;
    if (rst) begin
      m_mie = 0; m_mpie = 0; m_ie = 0; m_scratch = 0;
      m_epc = 0; m_cause = 0; m_tval = 0;
      m_cycle = 0; m_instret = 0;
      m_tvec = MTVEC_RST & ~64'h3;
      return;
    end
    if (req_valid && !trap_i && !mret_i) begin
      model_read(req_addr, ok, old);
      kind = req_op[1:0];
      wr = (kind == 2'd1) || !req_rs1_zero;
      e_valid = 1'b1;
      e_ill = !ok || kind == 2'd0 || (wr && req_addr >= 12'hC00);
      if (!e_ill) begin
        e_rdata = (kind == 2'd1 && !req_rd_v) ? 64'h0 : old;
        if (wr) begin
          if (kind == 2'd1)      nv = req_wdata;
          else if (kind == 2'd2) nv = old | req_wdata;
          else                   nv = old & ~req_wdata;
          case (req_addr)
            12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h304: m_ie = nv;
            12'h305: m_tvec = nv & ~64'h3;
            12'h340: m_scratch = nv;
            12'h341: m_epc = nv & ~64'h3;
            12'h342: m_cause = nv;
            12'h343: m_tval = nv;
            12'hB00: begin m_cycle = nv; cyc_w = 1; end
            12'hB02: begin m_instret = nv; ins_w = 1; end
            default: ;
          endcase
        end
      end
    end
    if (trap_i) begin
      m_epc = trap_epc_i & ~64'h3;
      m_cause = trap_cause_i;
      m_tval = trap_tval_i;
      m_mpie = m_mie;
      m_mie = 1'b0;
    end else if (mret_i) begin
      m_mie = m_mpie;
      m_mpie = 1'b1;
    end
    if (!cyc_w) m_cycle = m_cycle + 64'd1;
    if (!ins_w && retire_i) m_instret = m_instret + 64'd1;
  endtask

  task automatic tick();
    #1;
    chk("req_ready", 64'(req_ready), 64'(!trap_i && !mret_i));
    model_step();
    @(posedge clk);
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(e_valid));
    chk("rsp_illegal", 64'(rsp_illegal), 64'(e_ill));
    chk("rsp_rdata", rsp_rdata, e_rdata);
    chk("mtvec_o", mtvec_o, m_tvec);
    chk("mepc_o", mepc_o, m_epc);
  endtask

  task automatic do_req(input logic [2:0] op, input logic [11:0] a,
                        input logic [63:0] d, input logic z);
    req_valid = 1'b1;
    req_op = op;
    req_addr = a;
    req_wdata = d;
    req_rs1_zero = z;
    req_rd_v = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a);
    do_req(OP_RS, a, 64'h0, 1'b1);
  endtask

  initial begin
    rst = 1; req_valid = 0; req_op = 0; req_addr = 0;
    req_wdata = 0; req_rs1_zero = 0; req_rd_v = 1;
    retire_i = 0; trap_i = 0; mret_i = 0;
    trap_cause_i = 0; trap_epc_i = 0; trap_tval_i = 0;
    tick();
    tick();
    rst = 0;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rdata", rsp_rdata, 64'h0);
    chk("rst_mtvec", mtvec_o, 64'h1000);
    chk("rst_mepc", mepc_o, 64'h0);

    rd(12'hF14);
    chk("mhartid_valid", 64'(rsp_valid), 64'h1);
    chk("mhartid_rdata", rsp_rdata, 64'h0);
    chk("mhartid_illegal", 64'(rsp_illegal), 64'h0);
    tick();
    chk("rsp_one_cycle", 64'(rsp_valid), 64'h0);

    do_req(OP_RW, 12'h340, 64'hDEAD_BEEF, 1'b0);
    do_req(OP_RS, 12'h340, 64'hF0, 1'b0);
    chk("rs_old", rsp_rdata, 64'hDEAD_BEEF);
    rd(12'h340);
    chk("mscratch_set", rsp_rdata, 64'hDEAD_BEFF);

    do_req(OP_RC, 12'h300, 64'h0, 1'b1);
    rd(12'h300);
    chk("mstatus_nowrite", rsp_rdata, 64'h1800);
    do_req(OP_RW, 12'hF11, 64'h5, 1'b0);
    chk("ro_write_illegal", 64'(rsp_illegal), 64'h1);
    chk("ro_write_rdata", rsp_rdata, 64'h0);
    rd(12'h7FF);
    chk("bad_addr_illegal", 64'(rsp_illegal), 64'h1);

    do_req(OP_RW, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    tick();
    rd(12'hB00);
    chk("mcycle_wrap", rsp_rdata, 64'h0);

    rst = 1; tick(); rst = 0;
    retire_i = 1;
    repeat (5) tick();
    retire_i = 0;
    rd(12'hB02);
    chk("minstret_5", rsp_rdata, 64'd5);

    do_req(OP_RS, 12'h300, 64'h8, 1'b0);
    req_valid = 1; req_op = OP_RS; req_addr = 12'h340;
    req_wdata = 0; req_rs1_zero = 1;
    trap_i = 1; trap_cause_i = 64'd2;
    trap_epc_i = 64'h8000_0102; trap_tval_i = 64'h1234;
    #1;
    chk("trap_ready", 64'(req_ready), 64'h0);
    tick();
    trap_i = 0;
    chk("trap_no_rsp", 64'(rsp_valid), 64'h0);
    chk("trap_mepc", mepc_o, 64'h8000_0100);
    tick();
    req_valid = 0;
    chk("held_req_rsp", 64'(rsp_valid), 64'h1);
    rd(12'h300);
    chk("trap_mstatus", rsp_rdata, 64'h1880);
    rd(12'h342);
    chk("trap_mcause", rsp_rdata, 64'd2);

    mret_i = 1; tick(); mret_i = 0;
    rd(12'h300);
    chk("mret_mstatus", rsp_rdata, 64'h1888);

    do_req(OP_RW, 12'h300, 64'h0, 1'b0);
    trap_i = 1; mret_i = 1; trap_epc_i = 64'h44;
    tick();
    trap_i = 0; mret_i = 0;
    rd(12'h300);
    chk("trap_beats_mret", rsp_rdata, 64'h1800);

    req_valid = 1; req_op = OP_RS; req_addr = 12'h340;
    req_rs1_zero = 1; rst = 1;
    tick();
    rst = 0; req_valid = 0;
    chk("rst_drop_rsp", 64'(rsp_valid), 64'h0);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(99) == 0);
      req_valid = ($urandom_range(9) < 7);
      req_op = 3'($urandom_range(7));
      req_addr = addrs[$urandom_range(19)];
      req_rs1_zero = ($urandom_range(3) == 0);
      req_wdata = req_rs1_zero ? 64'h0 : {$urandom, $urandom};
      req_rd_v = ($urandom_range(9) != 0);
      retire_i = $urandom_range(1) == 1;
      trap_i = ($urandom_range(19) == 0);
      mret_i = ($urandom_range(19) == 0);
      trap_cause_i = {$urandom, $urandom};
      trap_epc_i = {$urandom, $urandom};
      trap_tval_i = {$urandom, $urandom};
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
